// File: rtl/fcd_fp_pkg.sv
// Shared FP32 constants and the scheduler state encoding for the dCollideSpheres
// sqrt path.
package fcd_fp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC00000;
  localparam logic [31:0] FP32_ONE      = 32'h3F800000;
  localparam int          FP32_SIGN_BIT = 31;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the grant goes to the first requester after
// ptr, wrapping around; en=0 suppresses every grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (en && !found && req[idx[IW-1:0]]) begin
        gnt[idx[IW-1:0]] = 1'b1;
        gnt_idx          = idx[IW-1:0];
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// Shares one iterative FP32 sqrt engine between N_REQ requesters; zero and negative
// operands are answered without the engine. SQRT_SCHED_TIMEOUT_EN adds a RUN watchdog.
module sqrt_sched
  import fcd_fp_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int LOAD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int ID_W          = $clog2(N_REQ)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_n,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_root,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_err,
  output logic                 eng_rst_n,
  output logic [31:0]          eng_n,
  input  logic [31:0]          eng_root,
  input  logic                 eng_rdy,
  output logic                 busy,
  output state_t               dbg_state
);

  localparam int LC_W = $clog2(LOAD_CYCLES + 1);

  state_t            r_state, w_next;
  logic [ID_W-1:0]   r_rr_ptr, r_rsp_id, w_gnt_idx;
  logic [N_REQ-1:0]  w_gnt;
  logic [31:0]       r_rsp_root, r_eng_n, w_sel_n;
  logic              r_rsp_err, r_first;
  logic              w_accept, w_zero, w_neg, w_done, w_timeout;
  logic [LC_W-1:0]   r_load_cnt;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (r_state == S_IDLE),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_sel_n = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_gnt[i]) w_sel_n = req_n[32*i +: 32];
  end

  assign w_accept = |(req_valid & w_gnt);
  assign w_zero   = (w_sel_n[30:0] == 31'd0);
  assign w_neg    = w_sel_n[FP32_SIGN_BIT];
  // The engine's ready flag can still be set from the previous operand on the first RUN cycle.
  assign w_done   = !r_first && eng_rdy;

`ifdef SQRT_SCHED_TIMEOUT_EN
  logic [15:0] r_run_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                  r_run_cnt <= '0;
    else if (r_state == S_RUN) r_run_cnt <= r_run_cnt + 16'd1;
    else                       r_run_cnt <= '0;
  end

  assign w_timeout = (r_state == S_RUN) && (r_run_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_zero || w_neg) ? S_RESP : S_LOAD;
      S_LOAD: if (r_load_cnt == LC_W'(LOAD_CYCLES - 1)) w_next = S_RUN;
      S_RUN:  if (w_done || w_timeout) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = w_gnt;
    rsp_valid = (r_state == S_RESP);
    eng_rst_n = (r_state == S_RUN);
    busy      = (r_state != S_IDLE);
    dbg_state = r_state;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rr_ptr   <= ID_W'(N_REQ - 1);
      r_rsp_id   <= '0;
      r_rsp_root <= '0;
      r_rsp_err  <= 1'b0;
      r_eng_n    <= '0;
      r_load_cnt <= '0;
      r_first    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rr_ptr   <= w_gnt_idx;
          r_rsp_id   <= w_gnt_idx;
          r_load_cnt <= '0;
          if (w_zero) begin
            r_rsp_root <= w_sel_n;
            r_rsp_err  <= 1'b0;
          end else if (w_neg) begin
            r_rsp_root <= FP32_QNAN;
            r_rsp_err  <= 1'b1;
          end else begin
            r_eng_n <= w_sel_n;
          end
        end
        S_LOAD: begin
          r_load_cnt <= r_load_cnt + LC_W'(1);
          r_first    <= 1'b1;
        end
        S_RUN: begin
          r_first <= 1'b0;
          if (w_done) begin
            r_rsp_root <= eng_root;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_root <= eng_root;
            r_rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_root = r_rsp_root;
  assign rsp_id   = r_rsp_id;
  assign rsp_err  = r_rsp_err;
  assign eng_n    = r_eng_n;

endmodule

// File: tb/tb_sqrt_sched.sv
// Bench for sqrt_sched: behavioural sqrt engine, requester slots, round-robin
// reference model and a response scoreboard. Define SQRT_SCHED_TIMEOUT_EN for the watchdog case.
module tb_sqrt_sched;
  import fcd_fp_pkg::*;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int LOADC = 2;
`ifdef SQRT_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [N-1:0]      req_valid, req_ready;
  logic [32*N-1:0]   req_n;
  logic              rsp_valid, rsp_ready, rsp_err, eng_rst_n, eng_rdy, busy;
  logic [31:0]       rsp_root, eng_n, eng_root;
  logic [IDW-1:0]    rsp_id;
  state_t            dbg_state;

  sqrt_sched #(.N_REQ(N), .LOAD_CYCLES(LOADC), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_n(req_n), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_root(rsp_root),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .eng_rst_n(eng_rst_n), .eng_n(eng_n), .eng_root(eng_root), .eng_rdy(eng_rdy),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // requester slots and scheduler reference state
  logic [N-1:0] pend_v = '0;
  logic [31:0]  pend_n [N];
  int           rdy_mode = 2;
  int           acc_slot = -1;
  int           mp = N - 1;
  int           cyc = 0;
  logic         in_flight = 1'b0, resp_seen = 1'b0, cur_byp = 1'b0;
  logic [31:0]  cur_n = '0;
  int           acc_cyc = 0, run_cnt = 0, load_cnt = 0;

  // scoreboard
  logic [31:0]    exp_root_q[$];
  logic [IDW-1:0] exp_id_q[$];
  logic [0:0]     exp_err_q[$];
  logic [15:0]    exp_lat_q[$];
  logic [15:0]    exp_run_q[$];
  logic [15:0]    exp_load_q[$];

  // engine model
  int          eng_lat = 0;
  logic        eng_stall = 1'b0;
  logic        e_rdy = 1'b0, e_started = 1'b0;
  logic [31:0] e_root = '0;
  int          e_cnt = 0;

  function automatic logic [31:0] sqrt_ref(input logic [31:0] n);
    case (n)
      32'h41800000: return 32'h40800000;  // 16    -> 4
      32'h40800000: return 32'h40000000;  // 4     -> 2
      32'h41100000: return 32'h40400000;  // 9     -> 3
      32'h41C80000: return 32'h40A00000;  // 25    -> 5
      32'h3E800000: return 32'h3F000000;  // 0.25  -> 0.5
      32'h3F800000: return 32'h3F800000;  // 1     -> 1
      32'h42800000: return 32'h41000000;  // 64    -> 8
      32'h40100000: return 32'h3FC00000;  // 2.25  -> 1.5
      default:      return 32'h7F800000;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    int          k = $urandom_range(0, 9);
    logic [31:0] r = $urandom;
    case (k)
      0: return 32'h41800000;
      1: return 32'h40800000;
      2: return 32'h41100000;
      3: return 32'h41C80000;
      4: return 32'h3E800000;
      5: return 32'h3F800000;
      6: return 32'h42800000;
      7: return 32'h40100000;
      8: return {1'b1, r[30:24], 1'b1, r[22:0]};
      default: return {r[0], 31'd0};
    endcase
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed budget expired expected DUT event", tag);
  endtask

  // Accepting slot idx: derive the whole expected outcome from the operand class.
  function automatic void model_accept(input int idx);
    logic [31:0] n = pend_n[idx];
    int          run;
    mp = idx; in_flight = 1'b1; resp_seen = 1'b0;
    acc_cyc = cyc; run_cnt = 0; load_cnt = 0; acc_slot = idx; cur_n = n;
    exp_id_q.push_back(IDW'(idx));
    if (n[30:0] == 31'd0) begin
      cur_byp = 1'b1;
      exp_root_q.push_back(n); exp_err_q.push_back(1'b0);
      exp_lat_q.push_back(16'd1); exp_run_q.push_back(16'd0); exp_load_q.push_back(16'd0);
    end else if (n[31]) begin
      cur_byp = 1'b1;
      exp_root_q.push_back(32'h7FC00000); exp_err_q.push_back(1'b1);
      exp_lat_q.push_back(16'd1); exp_run_q.push_back(16'd0); exp_load_q.push_back(16'd0);
    end else begin
      cur_byp = 1'b0;
      eng_lat = $urandom_range(0, 5);
      if (eng_stall) begin
        run = TO;
        exp_root_q.push_back(e_root); exp_err_q.push_back(1'b1);
      end else begin
        run = eng_lat + 3;
        exp_root_q.push_back(sqrt_ref(n)); exp_err_q.push_back(1'b0);
      end
      exp_lat_q.push_back(16'(1 + LOADC + run));
      exp_run_q.push_back(16'(run));
      exp_load_q.push_back(16'(LOADC));
    end
  endfunction

  // Engine: stale ready survives its reset, clears on the first released cycle,
  // then converges eng_lat cycles later.
  always @(posedge CLK) begin
    if (!eng_rst_n) begin
      e_cnt     <= eng_lat;
      e_started <= 1'b0;
    end else if (!e_started) begin
      e_started <= 1'b1;
      e_rdy     <= 1'b0;
    end else if (e_cnt == 0) begin
      if (!eng_stall) begin
        e_rdy  <= 1'b1;
        e_root <= sqrt_ref(eng_n);
      end
    end else begin
      e_cnt <= e_cnt - 1;
    end
  end
  assign eng_rdy  = e_rdy;
  assign eng_root = e_root;

  always @(negedge CLK) begin : monitor
    logic [N-1:0] exp_rdy, acc;
    int           w, idx;
    cyc++;
    if (RST) begin
      exp_rdy = '0;
      w = rr_pick(req_valid, mp);
      if (!in_flight && w >= 0) exp_rdy = N'(1) << w;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (in_flight && !rsp_valid) begin
        if (eng_rst_n) run_cnt++;
        else if (busy) load_cnt++;
        if (!cur_byp) check("eng_n", eng_n, cur_n);
      end
      if (rsp_valid) begin
        if (exp_root_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          check("rsp_root", rsp_root, exp_root_q[0]);
          check("rsp_id", 32'(rsp_id), 32'(exp_id_q[0]));
          check("rsp_err", 32'(rsp_err), 32'(exp_err_q[0]));
          if (!resp_seen) begin
            check("latency", 32'(cyc - acc_cyc), 32'(exp_lat_q[0]));
            check("run_cycles", 32'(run_cnt), 32'(exp_run_q[0]));
            check("load_cycles", 32'(load_cnt), 32'(exp_load_q[0]));
            resp_seen = 1'b1;
          end
          if (rsp_ready) begin
            void'(exp_root_q.pop_front()); void'(exp_id_q.pop_front());
            void'(exp_err_q.pop_front());  void'(exp_lat_q.pop_front());
            void'(exp_run_q.pop_front());  void'(exp_load_q.pop_front());
            in_flight = 1'b0;
            resp_seen = 1'b0;
          end
        end
      end
      acc = req_valid & req_ready;
      if (acc != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (acc[i]) idx = i;
        model_accept(idx);
      end
    end
  end

  task automatic drive();
    req_valid = pend_v;
    for (int i = 0; i < N; i++) req_n[32*i +: 32] = pend_n[i];
    case (rdy_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  endtask

  task automatic step();
    @(posedge CLK); #1;
    if (acc_slot >= 0) begin
      pend_v[acc_slot] = 1'b0;
      acc_slot = -1;
    end
    drive();
  endtask

  task automatic add_req(input int i, input logic [31:0] n);
    pend_n[i] = n;
    pend_v[i] = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    drive();
    while ((pend_v != '0 || in_flight) && k < budget) begin
      step();
      k++;
    end
    if (pend_v != '0 || in_flight) bound_fail(tag);
  endtask

  initial begin
    int s, k;
    for (int i = 0; i < N; i++) pend_n[i] = '0;
    rdy_mode = 2;
    drive();

    // reset values
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_root", rsp_root, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_eng_rst_n", 32'(eng_rst_n), 32'd0);
    check("rst_eng_n", eng_n, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    RST = 1'b1;

    // four simultaneous requests from reset pointer, then 1 and 3 after pointer=3
    add_req(0, 32'h40800000); add_req(1, 32'h41100000);
    add_req(2, 32'h41C80000); add_req(3, 32'h3E800000);
    drain("all_four", 200);
    add_req(1, 32'h41800000); add_req(3, 32'h42800000);
    drain("pair_1_3", 100);

    // single 16.0 on requester 0
    add_req(0, 32'h41800000);
    drain("single_16", 100);

    // negative, -0 and +0 bypass
    add_req(2, 32'hC0800000);
    drain("neg", 50);
    add_req(0, 32'h80000000);
    drain("neg_zero", 50);
    add_req(3, 32'h00000000);
    drain("pos_zero", 50);

    // consumer stall in RESP with another requester waiting
    rdy_mode = 1;
    add_req(1, 32'h41100000);
    drive();
    k = 0;
    while (!rsp_valid && k < 100) begin step(); k++; end
    if (!rsp_valid) bound_fail("wait_rsp_stall");
    add_req(2, 32'h40800000);
    drive();
    repeat (20) step();
    rdy_mode = 2;
    drain("after_stall", 100);

    // randomized traffic with drops and random consumer backpressure
    rdy_mode = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      s = $urandom_range(0, N - 1);
      if (!pend_v[s] && $urandom_range(0, 2) == 0) add_req(s, rand_operand());
      else if (pend_v[s] && $urandom_range(0, 19) == 0) pend_v[s] = 1'b0;
      drive();
    end
    rdy_mode = 2;
    drain("rand_drain", 2000);

    // asynchronous reset while the engine runs
    add_req(0, 32'h42800000);
    drive();
    k = 0;
    while (!eng_rst_n && k < 50) begin step(); k++; end
    if (!eng_rst_n) bound_fail("wait_run");
    #1 RST = 1'b0;
    #1;
    pend_v = '0; in_flight = 1'b0; resp_seen = 1'b0; mp = N - 1; acc_slot = -1;
    exp_root_q.delete(); exp_id_q.delete(); exp_err_q.delete();
    exp_lat_q.delete(); exp_run_q.delete(); exp_load_q.delete();
    drive();
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_root", rsp_root, 32'd0);
    check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    check("mid_rst_eng_rst_n", 32'(eng_rst_n), 32'd0);
    check("mid_rst_eng_n", eng_n, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    step(); step();
    #1 RST = 1'b1;
    add_req(2, 32'h41C80000); add_req(0, 32'h40100000);
    drain("post_reset", 100);

`ifdef SQRT_SCHED_TIMEOUT_EN
    // engine never converges
    eng_stall = 1'b1;
    add_req(1, 32'h41800000);
    drain("timeout", 200);
    eng_stall = 1'b0;
    add_req(3, 32'h40800000);
    drain("after_timeout", 100);
`endif

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
